serial_prod_acc: RTL and testbench

- Consumer end of the binary-serial multiplier border stage.
- Takes one gated partial product per cycle, each tagged with the bit index of the multiplier it belongs to. Weights each term by its index and accumulates a signed two's-complement product on top of an upstream partial sum.
- Emits the finished MAC result with a one-cycle valid pulse. Sits between the multiplier border and the next systolic PE / output drain.

---
 rtl/bs_pkg.sv | 20 ++
 rtl/shift_addsub.sv | 26 ++
 rtl/serial_prod_acc.sv | 127 ++++++++++++
 tb/tb_serial_prod_acc.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Definitions shared by the binary-serial multiplier border stage and its consumer:
// FSM state encoding, default geometry, and a geometry sanity check.
package bs_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 3;
  localparam int ACCW_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True when the index can address every term and the accumulator holds a full product.
  function automatic bit cfg_ok(input int width, input int depth, input int accw);
    return ((1 << depth) >= width) && (accw >= 2 * width);
  endfunction

endpackage

// File: rtl/shift_addsub.sv
// Weights one partial product by its bit index and folds it into the running sum;
// the sign-bit term is subtracted to give a two's-complement multiplier.
module shift_addsub
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACCW  = ACCW_DEF
) (
  input  logic signed [ACCW-1:0]    acc,
  input  logic signed [2*WIDTH-1:0] pp,
  input  logic        [DEPTH-1:0]   idx,
  input  logic                      sub,
  output logic signed [ACCW-1:0]    acc_next
);

  logic signed [ACCW-1:0] term_ext;
  logic signed [ACCW-1:0] term;

  always_comb begin
    term_ext = ACCW'(pp);
    term     = term_ext << idx;
    acc_next = sub ? (acc - term) : (acc + term);
  end

endmodule

// File: rtl/serial_prod_acc.sv
// Accumulates one index-tagged partial product per enabled cycle on top of an
// upstream partial sum and presents the finished MAC result with a one-cycle pulse.
module serial_prod_acc
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACCW  = ACCW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic        [DEPTH-1:0]   i_idx,
  input  logic signed [2*WIDTH-1:0] i_pp,
  input  logic signed [ACCW-1:0]    i_acc,
  input  logic                      i_acc_vld,
  output logic signed [ACCW-1:0]    o_acc,
  output logic                      o_acc_vld,
  output logic                      o_busy,
  output logic                      o_err
);

  state_e                  state_q, state_d;
  logic [DEPTH-1:0]        count_q, count_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [ACCW-1:0]  o_acc_q, o_acc_d;
  logic                    o_acc_vld_q, o_acc_vld_d;
  logic                    o_busy_q, o_busy_d;
  logic                    o_err_q, o_err_d;

  logic signed [ACCW-1:0]  acc_term;
  logic                    sign_term;
  logic                    last_term;

  assign sign_term = (i_idx == DEPTH'(WIDTH - 1));
  assign last_term = (count_q == DEPTH'(WIDTH - 1));

  shift_addsub #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ACCW  (ACCW)
  ) u_shift_addsub (
    .acc      (acc_q),
    .pp       (i_pp),
    .idx      (i_idx),
    .sub      (sign_term),
    .acc_next (acc_term)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    o_acc_d = o_acc_q;
    o_err_d = o_err_q;

    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      acc_d   = '0;
      o_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_acc_vld) begin
            state_d = ACCUM;
            count_d = '0;
            acc_d   = i_acc;
          end
        end
        ACCUM: begin
          if (en) begin
            acc_d   = acc_term;
            count_d = count_q + 1'b1;
            // A mis-sequenced index is flagged but still used as the term weight.
            if (i_idx != count_q) o_err_d = 1'b1;
            if (last_term) begin
              state_d = DONE;
              o_acc_d = acc_term;
            end
          end
        end
        DONE: begin
          // Accepting a start here gives back-to-back operation without a bubble.
          if (i_acc_vld) begin
            state_d = ACCUM;
            count_d = '0;
            acc_d   = i_acc;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    o_acc_vld_d = (state_d == DONE);
    o_busy_d    = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      o_acc_q     <= '0;
      o_acc_vld_q <= 1'b0;
      o_busy_q    <= 1'b0;
      o_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      o_acc_q     <= o_acc_d;
      o_acc_vld_q <= o_acc_vld_d;
      o_busy_q    <= o_busy_d;
      o_err_q     <= o_err_d;
    end
  end

  assign o_acc     = o_acc_q;
  assign o_acc_vld = o_acc_vld_q;
  assign o_busy    = o_busy_q;
  assign o_err     = o_err_q;

endmodule

// File: tb/tb_serial_prod_acc.sv
// Scenario bench for serial_prod_acc: directed corner cases plus randomized MACs
// checked against a plain-arithmetic multiply-accumulate reference.
module tb_serial_prod_acc;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int ACCW  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      en;
  logic                      clr;
  logic        [DEPTH-1:0]   i_idx;
  logic signed [2*WIDTH-1:0] i_pp;
  logic signed [ACCW-1:0]    i_acc;
  logic                      i_acc_vld;
  logic signed [ACCW-1:0]    o_acc;
  logic                      o_acc_vld;
  logic                      o_busy;
  logic                      o_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_pulses = 0;
  logic [31:0] exp_last = 32'd0;

  serial_prod_acc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .i_idx     (i_idx),
    .i_pp      (i_pp),
    .i_acc     (i_acc),
    .i_acc_vld (i_acc_vld),
    .o_acc     (o_acc),
    .o_acc_vld (o_acc_vld),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_acc_vld === 1'b1) vld_pulses <= vld_pulses + 1;

  // Reference: the whole operation is just acc + multiplicand * multiplier, both signed.
  function automatic logic [31:0] mac_model(input logic [31:0] acc_in, input logic [7:0] mcand,
                                            input logic [7:0] mplier);
    int m, q;
    m = int'($signed(mcand));
    q = int'($signed(mplier));
    return acc_in + 32'(m * q);
  endfunction

  function automatic logic signed [15:0] sext(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a);
    i_acc_vld = 1'b1;
    i_acc     = a;
    tick();
    i_acc_vld = 1'b0;
    i_acc     = 32'($urandom);
  endtask

  // Feeds the WIDTH terms of mcand*mplier in order, with optional random stalls and start noise.
  task automatic feed_terms(input logic [7:0] mcand, input logic [7:0] mplier, input int stall_pct,
                            output int busy_low, output int n_stall);
    busy_low = 0;
    n_stall  = 0;
    for (int b = 0; b < WIDTH; b++) begin
      while (int'($urandom_range(99)) < stall_pct) begin
        if (o_busy !== 1'b1) busy_low++;
        en        = 1'b0;
        i_idx     = 3'($urandom);
        i_pp      = 16'($urandom);
        i_acc_vld = 1'($urandom_range(1));
        i_acc     = 32'($urandom);
        n_stall++;
        tick();
      end
      if (o_busy !== 1'b1) busy_low++;
      en        = 1'b1;
      i_idx     = DEPTH'(b);
      i_pp      = mplier[b] ? sext(mcand) : 16'sd0;
      i_acc_vld = (stall_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
      i_acc     = 32'($urandom);
      tick();
    end
    en        = 1'b0;
    i_acc_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_idx = '0; i_pp = '0; i_acc = '0; i_acc_vld = 1'b0;
    repeat (3) tick();
    checks++; if (o_acc !== 32'd0) begin errors++; $display("FAIL reset_o_acc got %0h exp 0", o_acc); end
    checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", o_acc_vld); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int s, bl, ns;
    logic [31:0] exp;
    exp = mac_model(32'd0, 8'd5, 8'd3);
    // Enables in IDLE must be ignored.
    en = 1'b1; i_idx = 3'd0; i_pp = 16'sd99; tick(); en = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_en got busy %b exp 0", o_busy); end
    start(32'd0);
    s = cyc;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b exp 1", o_busy); end
    feed_terms(8'd5, 8'd3, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", o_acc_vld); end
    checks++; if (cyc - s !== WIDTH) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc - s, WIDTH); end
    checks++; if (o_acc !== exp) begin errors++; $display("FAIL basic_o_acc got %0d exp %0d", o_acc, exp); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", o_busy); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL basic_busy_low got %0d exp 0", bl); end
    tick();
    checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_pulse got %b exp 0", o_acc_vld); end
    checks++; if (o_acc !== exp) begin errors++; $display("FAIL basic_o_acc_hold got %0d exp %0d", o_acc, exp); end
    exp_last = exp;
    $display("test_basic 5*3 o_acc=%0d", o_acc);
  endtask

  task automatic test_signed();
    int bl, ns;
    logic [31:0] exp;
    exp = mac_model(32'd0, 8'hFF, 8'h80);
    start(32'd0);
    feed_terms(8'hFF, 8'h80, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== exp) begin errors++; $display("FAIL signed_m1_m128 got vld %b acc %0d exp %0d", o_acc_vld, o_acc, exp); end
    tick();
    exp = mac_model(32'd100, 8'd7, 8'hFD);
    start(32'd100);
    feed_terms(8'd7, 8'hFD, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== exp) begin errors++; $display("FAIL signed_7_m3 got vld %b acc %0d exp %0d", o_acc_vld, o_acc, exp); end
    exp_last = exp;
    tick();
    $display("test_signed 7*-3+100 o_acc=%0d", o_acc);
  endtask

  task automatic test_stall();
    int s;
    logic [31:0] exp;
    exp = mac_model(32'd0, 8'd5, 8'd3);
    start(32'd0);
    s = cyc;
    for (int b = 0; b < WIDTH; b++) begin
      if (b == 3) begin
        for (int k = 0; k < 3; k++) begin
          en = 1'b0; i_idx = 3'($urandom); i_pp = 16'($urandom);
          checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", o_busy); end
          tick();
        end
      end
      en = 1'b1; i_idx = DEPTH'(b); i_pp = (b < 2) ? 16'sd5 : 16'sd0;
      tick();
    end
    en = 1'b0;
    checks++; if (o_acc_vld !== 1'b1) begin errors++; $display("FAIL stall_vld got %b exp 1", o_acc_vld); end
    checks++; if (cyc - s !== WIDTH + 3) begin errors++; $display("FAIL stall_latency got %0d exp %0d", cyc - s, WIDTH + 3); end
    checks++; if (o_acc !== exp) begin errors++; $display("FAIL stall_o_acc got %0d exp %0d", o_acc, exp); end
    exp_last = exp;
    tick();
    $display("test_stall o_acc=%0d", o_acc);
  endtask

  task automatic test_abort();
    int p0, bl, ns;
    logic [31:0] exp;
    start(32'd0);
    for (int b = 0; b < 4; b++) begin
      en = 1'b1; i_idx = DEPTH'(b); i_pp = (b < 2) ? 16'sd5 : 16'sd0;
      tick();
    end
    // clr wins over both en and a start request in the same cycle.
    en = 1'b1; i_idx = 3'd4; i_pp = 16'sd0; clr = 1'b1; i_acc_vld = 1'b1; i_acc = 32'd77;
    tick();
    en = 1'b0; clr = 1'b0; i_acc_vld = 1'b0;
    p0 = vld_pulses;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", o_busy); end
    checks++; if (o_acc !== exp_last) begin errors++; $display("FAIL abort_o_acc_kept got %0d exp %0d", o_acc, exp_last); end
    repeat (WIDTH + 2) tick();
    checks++; if (vld_pulses !== p0) begin errors++; $display("FAIL abort_no_pulse got %0d pulses exp 0", vld_pulses - p0); end
    exp = mac_model(32'd10, 8'd2, 8'd1);
    start(32'd10);
    feed_terms(8'd2, 8'd1, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== exp) begin errors++; $display("FAIL abort_restart got vld %b acc %0d exp %0d", o_acc_vld, o_acc, exp); end
    exp_last = exp;
    tick();
    $display("test_abort restart o_acc=%0d", o_acc);
  endtask

  task automatic test_back_to_back();
    int c1, bl, ns;
    logic [31:0] e1, e2;
    e1 = mac_model(32'd1000, 8'd33, 8'd9);
    e2 = mac_model(32'hFFFF_FFF0, 8'hC3, 8'h5A);
    start(32'd1000);
    feed_terms(8'd33, 8'd9, 0, bl, ns);
    c1 = cyc;
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== e1) begin errors++; $display("FAIL b2b_first got vld %b acc %0d exp %0d", o_acc_vld, o_acc, e1); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done got %b exp 0", o_busy); end
    start(32'hFFFF_FFF0);
    checks++; if (o_busy !== 1'b1 || o_acc_vld !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy %b vld %b exp 1 0", o_busy, o_acc_vld); end
    feed_terms(8'hC3, 8'h5A, 0, bl, ns);
    checks++; if (bl !== 0) begin errors++; $display("FAIL b2b_busy_low got %0d exp 0", bl); end
    checks++; if (cyc - c1 !== WIDTH + 1) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", cyc - c1, WIDTH + 1); end
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== e2) begin errors++; $display("FAIL b2b_second got vld %b acc %0d exp %0d", o_acc_vld, o_acc, e2); end
    exp_last = e2;
    tick();
    $display("test_back_to_back o_acc=%0d", o_acc);
  endtask

  task automatic test_error();
    int idxs[8] = '{0, 1, 3, 4, 5, 6, 7, 7};
    int exp_i;
    exp_i = 0;
    foreach (idxs[k]) exp_i += (idxs[k] == WIDTH - 1) ? -(1 << idxs[k]) : (1 << idxs[k]);
    start(32'd0);
    foreach (idxs[k]) begin
      en = 1'b1; i_idx = DEPTH'(idxs[k]); i_pp = 16'sd1;
      tick();
      if (k == 1) begin
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", o_err); end
      end
      if (k == 2) begin
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", o_err); end
      end
    end
    en = 1'b0;
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== 32'(exp_i)) begin errors++; $display("FAIL err_result got vld %b acc %0d exp %0d", o_acc_vld, o_acc, exp_i); end
    exp_last = 32'(exp_i);
    repeat (3) tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", o_err); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", o_err); end
    checks++; if (o_acc !== exp_last) begin errors++; $display("FAIL err_clr_o_acc got %0d exp %0d", o_acc, exp_last); end
    $display("test_error o_acc=%0d", o_acc);
  endtask

  task automatic test_wrap();
    int bl, ns;
    logic [31:0] exp;
    exp = mac_model(32'h7FFF_FFFF, 8'd1, 8'd1);
    start(32'h7FFF_FFFF);
    feed_terms(8'd1, 8'd1, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== exp || exp !== 32'h8000_0000) begin errors++; $display("FAIL wrap got %0h exp %0h", o_acc, exp); end
    exp_last = exp;
    tick();
    $display("test_wrap o_acc=%0h", o_acc);
  endtask

  task automatic test_reset_mid();
    int bl, ns;
    start(32'd123);
    for (int b = 0; b < 3; b++) begin
      en = 1'b1; i_idx = (b == 1) ? 3'd2 : DEPTH'(b); i_pp = 16'sd50;
      tick();
    end
    en = 1'b0;
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got err %b busy %b exp 1 1", o_err, o_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_acc !== 32'd0 || o_busy !== 1'b0 || o_err !== 1'b0 || o_acc_vld !== 1'b0) begin
      errors++; $display("FAIL rmid_async got acc %0d busy %b err %b vld %b exp 0 0 0 0", o_acc, o_busy, o_err, o_acc_vld);
    end
    tick();
    #3 rst_n = 1'b1;
    tick();
    start(32'd0);
    feed_terms(8'd5, 8'd3, 0, bl, ns);
    checks++; if (o_acc_vld !== 1'b1 || o_acc !== 32'd15) begin errors++; $display("FAIL rmid_fresh got vld %b acc %0d exp 15", o_acc_vld, o_acc); end
    exp_last = 32'd15;
    tick();
    $display("test_reset_mid o_acc=%0d", o_acc);
  endtask

  task automatic test_random();
    int s, bl, ns;
    logic [7:0] mc, mp;
    logic [31:0] a, exp;
    for (int n = 0; n < 25; n++) begin
      mc = 8'($urandom); mp = 8'($urandom); a = 32'($urandom);
      if (n % 5 == 0) a = 32'h7FFF_FF00 + 32'($urandom_range(255));
      exp = mac_model(a, mc, mp);
      en = 1'b1; i_pp = 16'($urandom); i_idx = 3'($urandom); tick(); en = 1'b0;
      start(a);
      s = cyc;
      feed_terms(mc, mp, 30, bl, ns);
      checks++; if (o_acc_vld !== 1'b1 || o_acc !== exp) begin errors++; $display("FAIL rand_%0d mc %0d mp %0d acc %0h got vld %b %0h exp %0h", n, mc, mp, a, o_acc_vld, o_acc, exp); end
      checks++; if (cyc - s !== WIDTH + ns || bl !== 0) begin errors++; $display("FAIL rand_timing_%0d got lat %0d busy_low %0d exp %0d 0", n, cyc - s, bl, WIDTH + ns); end
      $display("rand %0d: %0d*%0d+%0h -> %0h stalls %0d", n, $signed(mc), $signed(mp), a, o_acc, ns);
      tick();
    end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rand_err got %b exp 0", o_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_abort();
    test_back_to_back();
    test_error();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
